// File: rtl/ps2_pkg.sv
// Shared constants and FSM encoding for the PS/2 keyboard front end.
// Scancode prefixes and frame layout live here.
package ps2_pkg;

  localparam logic [7:0] CODE_BREAK = 8'hF0;
  localparam logic [7:0] CODE_EXT   = 8'hE0;
  localparam int         FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: pad sync, falling-edge detect,
// bit FSM and inactivity timeout. Emits one valid byte per good frame.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err,
  output logic       timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic dat_s1_q, dat_s2_q;

  ps2_state_e    state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic fall;
  logic tmo_hit;
  logic stop_ok;

  assign fall    = clk_prev_q & ~clk_s2_q;
  // An edge in the same cycle as expiry keeps the frame alive.
  assign tmo_hit = (state_q != IDLE) && !fall && (tmo_q == TMO_LAST);
  assign stop_ok = dat_s2_q & (^{shift_q, par_q});

  always_ff @(posedge clock) begin
    if (reset) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tmo_q      <= '0;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_data;
      dat_s2_q   <= dat_s1_q;
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tmo_q      <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fall && !dat_s2_q) state_d = DATA;
      DATA:    if (fall && bitcnt_q == 3'd7) state_d = PARITY;
      PARITY:  if (fall) state_d = STOP;
      STOP:    if (fall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (tmo_hit) state_d = IDLE;
  end

  always_comb begin
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    if (fall || state_q == IDLE || tmo_hit) tmo_d = '0;
    else tmo_d = tmo_q + TW'(1);
    if (fall) begin
      unique case (state_q)
        IDLE: bitcnt_d = 3'd0;
        DATA: begin
          shift_d[bitcnt_q] = dat_s2_q;
          bitcnt_d = bitcnt_q + 3'd1;
        end
        PARITY:  par_d = dat_s2_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    byte_valid = (state_q == STOP) && fall && stop_ok;
    frame_err  = ((state_q == STOP) && fall && !stop_ok) || tmo_hit;
    timeout    = tmo_hit;
    rx_byte    = shift_q;
  end

endmodule

// File: rtl/ps2_key_src.sv
// Keyboard source for the register file: turns PS/2 scancodes into
// one gpi_we strobe per make code, dropping break sequences.
module ps2_key_src
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] gpi,
  output logic       gpi_we,
  output logic       ext_flag,
  output logic       frame_err
);

  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       rx_err;
  logic       rx_tmo;

  logic [7:0] gpi_q, gpi_d;
  logic       gpi_we_q, gpi_we_d;
  logic       ext_flag_q, ext_flag_d;
  logic       frame_err_q, frame_err_d;
  logic       brk_pend_q, brk_pend_d;
  logic       ext_pend_q, ext_pend_d;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clock     (clock),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_valid(byte_valid),
    .rx_byte   (rx_byte),
    .frame_err (rx_err),
    .timeout   (rx_tmo)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      gpi_q       <= '0;
      gpi_we_q    <= 1'b0;
      ext_flag_q  <= 1'b0;
      frame_err_q <= 1'b0;
      brk_pend_q  <= 1'b0;
      ext_pend_q  <= 1'b0;
    end else begin
      gpi_q       <= gpi_d;
      gpi_we_q    <= gpi_we_d;
      ext_flag_q  <= ext_flag_d;
      frame_err_q <= frame_err_d;
      brk_pend_q  <= brk_pend_d;
      ext_pend_q  <= ext_pend_d;
    end
  end

  always_comb begin
    gpi_d       = gpi_q;
    gpi_we_d    = 1'b0;
    ext_flag_d  = ext_flag_q;
    frame_err_d = rx_err;
    brk_pend_d  = brk_pend_q;
    ext_pend_d  = ext_pend_q;
    if (rx_tmo) begin
      brk_pend_d = 1'b0;
      ext_pend_d = 1'b0;
    end
    if (byte_valid) begin
      unique case (1'b1)
        rx_byte == CODE_BREAK: brk_pend_d = 1'b1;
        rx_byte == CODE_EXT:   ext_pend_d = 1'b1;
        brk_pend_q: begin
          brk_pend_d = 1'b0;
          ext_pend_d = 1'b0;
        end
        default: begin
          gpi_d      = rx_byte;
          ext_flag_d = ext_pend_q;
          gpi_we_d   = 1'b1;
          ext_pend_d = 1'b0;
        end
      endcase
    end
  end

  assign gpi       = gpi_q;
  assign gpi_we    = gpi_we_q;
  assign ext_flag  = ext_flag_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_src.sv
// Bench for ps2_key_src: table of PS/2 frames with expected outputs,
// a pulse scoreboard, and hand sequences for timeout and reset.
module tb_ps2_key_src;

  localparam int TMO = 200;

  logic       clock = 1'b0;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] gpi;
  logic       gpi_we;
  logic       ext_flag;
  logic       frame_err;

  int checks   = 0;
  int failures = 0;
  int we_cnt   = 0;
  int err_cnt  = 0;

  typedef struct packed {
    logic [7:0] gpi;
    logic       ext;
  } exp_t;

  exp_t sb_q[$];

  typedef struct {
    logic [7:0] code;
    logic       bad_par;
    logic       bad_stop;
    int         exp_we;
    int         exp_err;
    logic [7:0] exp_gpi;
    logic       exp_ext;
  } vec_t;

  ps2_key_src #(
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .gpi      (gpi),
    .gpi_we   (gpi_we),
    .ext_flag (ext_flag),
    .frame_err(frame_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (frame_err) err_cnt++;
    if (gpi_we) begin
      exp_t e;
      we_cnt++;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: gpi_we with gpi=%0h, none expected",
                 gpi);
      end else begin
        e = sb_q.pop_front();
        if (gpi !== e.gpi || ext_flag !== e.ext) begin
          failures++;
          $display("FAIL sb_pulse: got gpi=%0h ext=%0b expected gpi=%0h ext=%0b",
                   gpi, ext_flag, e.gpi, e.ext);
        end
      end
    end
  end

  // Sends the first n bits (LSB first) of an 11-bit frame.
  task automatic ps2_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      ps2_data = bits[i];
      repeat (20) @(negedge clock);
      ps2_clk = 1'b0;
      repeat (20) @(negedge clock);
      ps2_clk = 1'b1;
    end
    @(negedge clock);
    ps2_data = 1'b1;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] c,
                                           input logic bp,
                                           input logic bs);
    logic par;
    par = ~(^c) ^ bp;
    return {~bs, par, c, 1'b0};
  endfunction

  task automatic send(input logic [7:0] c, input logic bp,
                      input logic bs);
    ps2_bits(mk_frame(c, bp, bs), 11);
    repeat (10) @(negedge clock);
  endtask

  vec_t vecs[12];

  initial begin
    int we0, err0;
    vecs[0]  = '{8'h1C, 0, 0, 1, 0, 8'h1C, 0};
    vecs[1]  = '{8'hF0, 0, 0, 0, 0, 8'h1C, 0};
    vecs[2]  = '{8'h1C, 0, 0, 0, 0, 8'h1C, 0};
    vecs[3]  = '{8'hE0, 0, 0, 0, 0, 8'h1C, 0};
    vecs[4]  = '{8'h75, 0, 0, 1, 0, 8'h75, 1};
    vecs[5]  = '{8'hE0, 0, 0, 0, 0, 8'h75, 1};
    vecs[6]  = '{8'hF0, 0, 0, 0, 0, 8'h75, 1};
    vecs[7]  = '{8'h75, 0, 0, 0, 0, 8'h75, 1};
    vecs[8]  = '{8'h1C, 1, 0, 0, 1, 8'h75, 1};
    vecs[9]  = '{8'h32, 0, 0, 1, 0, 8'h32, 0};
    vecs[10] = '{8'h44, 0, 1, 0, 1, 8'h32, 0};
    vecs[11] = '{8'h29, 0, 0, 1, 0, 8'h29, 0};

    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clock);
    chk("rst_gpi", 32'(gpi), 32'h0);
    chk("rst_we", 32'(gpi_we), 32'h0);
    chk("rst_ext", 32'(ext_flag), 32'h0);
    chk("rst_err", 32'(frame_err), 32'h0);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    for (int i = 0; i < 12; i++) begin
      we0  = we_cnt;
      err0 = err_cnt;
      if (vecs[i].exp_we != 0)
        sb_q.push_back('{vecs[i].exp_gpi, vecs[i].exp_ext});
      send(vecs[i].code, vecs[i].bad_par, vecs[i].bad_stop);
      chk($sformatf("v%0d_we", i), 32'(we_cnt - we0), 32'(vecs[i].exp_we));
      chk($sformatf("v%0d_err", i), 32'(err_cnt - err0),
          32'(vecs[i].exp_err));
      chk($sformatf("v%0d_gpi", i), 32'(gpi), 32'(vecs[i].exp_gpi));
      chk($sformatf("v%0d_ext", i), 32'(ext_flag), 32'(vecs[i].exp_ext));
    end

    // Timeout: break prefix then a stalled frame; timeout clears brk_pend.
    send(8'hF0, 0, 0);
    we0  = we_cnt;
    err0 = err_cnt;
    ps2_bits(mk_frame(8'h55, 0, 0), 5);
    repeat (TMO + 100) @(negedge clock);
    chk("tmo_err", 32'(err_cnt - err0), 32'd1);
    chk("tmo_we", 32'(we_cnt - we0), 32'd0);
    sb_q.push_back('{8'h29, 1'b0});
    send(8'h29, 0, 0);
    chk("tmo_next_we", 32'(we_cnt - we0), 32'd1);
    chk("tmo_next_gpi", 32'(gpi), 32'h29);

    // Reset mid-frame after d3, with a break pending beforehand.
    send(8'hF0, 0, 0);
    we0  = we_cnt;
    err0 = err_cnt;
    ps2_bits(mk_frame(8'h6B, 0, 0), 5);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("mrst_gpi", 32'(gpi), 32'h0);
    chk("mrst_ext", 32'(ext_flag), 32'h0);
    chk("mrst_we", 32'(gpi_we), 32'h0);
    chk("mrst_err", 32'(frame_err), 32'h0);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    sb_q.push_back('{8'h5A, 1'b0});
    send(8'h5A, 0, 0);
    chk("mrst_next_we", 32'(we_cnt - we0), 32'd1);
    chk("mrst_next_err", 32'(err_cnt - err0), 32'd0);
    chk("mrst_next_gpi", 32'(gpi), 32'h5A);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_key_src.md
Name: ps2_key_src

Overview:
- Keyboard front end that produces the `gpi` / `gpi_we` pair consumed by the CPU register file.
- The register file writes `gpi` into R13 and sets flag F on each `gpi_we`.
- This block receives PS/2 device-to-host frames and decodes the scancode stream.
- It emits exactly one single-cycle `gpi_we` pulse per key press (make code); key releases (break codes) are suppressed.

Parameters:
- TIMEOUT_CYCLES, 50000, system-clock cycles with no `ps2_clk` falling edge before a partial frame is abandoned (1 ms at 50 MHz).
- CODE_BREAK, 8'hF0, scancode prefix marking a key release.
- CODE_EXT, 8'hE0, scancode prefix marking an extended key.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- ps2_clk  in  1  raw PS/2 clock from pad, asynchronous.
- ps2_data  in  1  raw PS/2 data from pad, asynchronous.
- gpi  out  8  last make-code byte; drives the register-file `gpi`.
- gpi_we  out  1  one-cycle strobe, high when `gpi` is new; drives the register-file `gpi_we`.
- ext_flag  out  1  1 when the current `gpi` was preceded by CODE_EXT; updated together with `gpi`.
- frame_err  out  1  one-cycle pulse on parity error, bad stop bit, or timeout.

Behaviour:
- Reset values: `gpi`=0, `gpi_we`=0, `ext_flag`=0, `frame_err`=0. Synchronizers are cleared to 1 (line idle). FSM goes to IDLE. All pending flags are cleared.
- Synchronisation: `ps2_clk` and `ps2_data` each pass through 2 flip-flops.
- Edge detect: a falling edge is synced clk 1 in the previous cycle and 0 in the current cycle. It is seen 2–3 cycles after the pad edge. Data is sampled in the same cycle as the detected edge.
- Frame format: 11 bits, LSB first — start(0), d0..d7, parity (odd over d0..d7 + parity), stop(1).
- FSM states and transitions:
  - IDLE: on an edge, if data=0 go to DATA with bitcnt=0; if data=1 ignore and stay in IDLE (no error).
  - DATA: on an edge, shift data into bit `bitcnt` and increment. After d7 (bitcnt==7) go to PARITY.
  - PARITY: on an edge, latch the parity bit and go to STOP.
  - STOP: on an edge, if stop=1 and parity is odd, the byte is valid; otherwise pulse `frame_err`. Either way, go to IDLE.
- Timeout counter: reset to 0 on every edge and held at 0 in IDLE. In any other state it counts every cycle. When it reaches TIMEOUT_CYCLES-1, the FSM goes to IDLE, `frame_err` pulses, and both pending flags clear.
- Decoder: runs in the cycle after the valid-byte cycle (cycle N+1 if the stop edge is in cycle N).
  - byte==CODE_BREAK: set `brk_pend`; no output.
  - byte==CODE_EXT: set `ext_pend`; no output.
  - Otherwise, if `brk_pend` is set: clear `brk_pend` and `ext_pend`; no output (release suppressed).
  - Otherwise: `gpi`<=byte, `ext_flag`<=`ext_pend`, `gpi_we`=1 in cycle N+1 only, then clear `ext_pend`.
- Latency: `gpi_we` is high exactly one cycle, in cycle N+1 after the stop-bit edge. `gpi` and `ext_flag` hold until the next make code.
- Invalid frames (parity or stop error): the byte is discarded and the pending flags are unchanged.
- No back-pressure: consecutive make codes produce separate pulses. The minimum spacing is one full frame (far longer than one CPU cycle).
- Reset asserted mid-frame: the partial frame is dropped, no pulse is issued, and after release the FSM waits for a new start bit.
- Simultaneous timeout and edge in the same cycle: the edge wins and the timer resets.

Decomposition:
- Package `ps2_pkg`: CODE_BREAK, CODE_EXT, FSM state enum {IDLE, DATA, PARITY, STOP}, frame length constant 11.
- Sub-module `ps2_frame_rx`: synchronizers, edge detect, FSM, timeout. Outputs `byte_valid`, `byte`, and the error pulse.
- `ps2_key_src`: instantiates `ps2_frame_rx` and implements the break/extended decoder and output registers.

Test Plan:
- Frame 8'h1C (A make), odd parity, stop=1, ps2_clk period 40 cycles -> one `gpi_we` pulse with `gpi`=8'h1C, `ext_flag`=0, `frame_err` never asserted.
- Sequence F0,1C after a 1C press -> no `gpi_we` for the release; `gpi` stays 8'h1C.
- Sequence E0,75 (up arrow) then E0,F0,75 -> exactly one pulse with `gpi`=8'h75, `ext_flag`=1; the release is suppressed and `ext_pend` is clear afterwards.
- Frame 8'h1C with wrong parity bit -> `frame_err` pulses once, no `gpi_we`; a following good 8'h32 produces `gpi`=8'h32.
- 5 bits of a frame, then the clock stops for TIMEOUT_CYCLES (use 200 in sim) -> `frame_err` at the timeout; the next full 8'h29 frame decodes correctly.
- Reset pulsed after bit d3 of a frame -> all outputs 0, no pulse; the next clean 8'h5A frame yields `gpi`=8'h5A with one `gpi_we`.
